controlador_int: RTL and testbench

Priority interrupt controller for the single-cycle CPU. It synchronizes eight external interrupt lines, latches rising edges as pending requests, and applies the mask and global enable. It presents one prioritized request with its vector to the control unit over a request/acknowledge handshake, then tracks in-service levels until return-from-interrupt. It sits between the external lines and the control unit's interrupt input.

---
 rtl/controlador_int_if.sv | 39 +++
 rtl/controlador_int.sv | 255 +++++++++++++++++++++++++
 tb/tb_controlador_int.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/controlador_int_if.sv
// ---------------------------------------------------------------------------
// controlador_int_if
//   Request/acknowledge channel between the interrupt controller and the
//   control unit of the single-cycle CPU.
//
//   Signals:
//     int_req  controller -> CPU  registered interrupt request
//     int_vec  controller -> CPU  vector address, valid while int_req = 1
//     int_id   controller -> CPU  line index, valid while int_req = 1
//     int_ack  CPU -> controller  one-cycle pulse when the request is taken
//     reti     CPU -> controller  one-cycle pulse on return-from-interrupt
//
//   Modports:
//     master   the interrupt controller (drives the request side)
//     slave    the control unit (drives ack and reti)
// ---------------------------------------------------------------------------
interface controlador_int_if;
  logic       int_req;
  logic [7:0] int_vec;
  logic [2:0] int_id;
  logic       int_ack;
  logic       reti;

  modport master (
    output int_req,
    output int_vec,
    output int_id,
    input  int_ack,
    input  reti
  );

  modport slave (
    input  int_req,
    input  int_vec,
    input  int_id,
    output int_ack,
    output reti
  );
endinterface

// File: rtl/controlador_int.sv
// ---------------------------------------------------------------------------
// controlador_int
//   Priority interrupt controller for the single-cycle CPU. Eight external
//   lines are synchronized, their rising edges are latched as pending
//   requests, and the mask plus global enable (gie) decide which lines may
//   interrupt. The lowest-index qualifying line is offered to the control
//   unit with its vector; once acknowledged the line moves to in-service
//   until return-from-interrupt.
//
//   Parameters:
//     VEC_BASE   base address of the vector table
//     VEC_SHIFT  vector stride is 2^VEC_SHIFT words (address wraps mod 256)
//
//   Ports:
//     clk           system clock, rising edge
//     rst           asynchronous active-high reset, clears all state
//     i_irq         raw interrupt lines, asynchronous; bit 0 = top priority
//     i_mask_we     mask register write strobe
//     i_mask_d      new mask value, 1 = line enabled
//     i_ien_set     set gie (ei instruction)
//     i_ien_clr     clear gie (di instruction), wins over every gie set
//     bus           request/ack channel (int_req, int_vec, int_id,
//                   int_ack, reti)
//     o_pending     pending register
//     o_in_service  in-service register
//
//   Configuration macro:
//     NESTING_EN    when defined, a line strictly above the highest-priority
//                   in-service level may preempt once gie is re-enabled.
//                   When undefined, no request is raised while anything is
//                   in service and reti clears in_service entirely.
// ---------------------------------------------------------------------------
module controlador_int #(
  parameter logic [7:0] VEC_BASE  = 8'hF0,
  parameter int         VEC_SHIFT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               i_irq,
  input  logic                     i_mask_we,
  input  logic [7:0]               i_mask_d,
  input  logic                     i_ien_set,
  input  logic                     i_ien_clr,
  controlador_int_if.master        bus,
  output logic [7:0]               o_pending,
  output logic [7:0]               o_in_service
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  logic [7:0] r_s1;
  logic [7:0] r_s2;
  logic [7:0] r_s3;
  logic [7:0] r_mask;
  logic [7:0] r_pending;
  logic [7:0] r_in_service;
  logic       r_gie;
  logic       r_int_req;
  logic [2:0] r_int_id;
  logic [7:0] r_int_vec;

  logic [7:0] w_edge;
  logic [7:0] w_prio_ok;
  logic [7:0] w_cand;
  logic       w_win_valid;
  logic [2:0] w_win_id;
  logic [7:0] w_win_vec;
  logic       w_latched_ok;
  logic       w_ack_taken;
  logic       w_reti_valid;

  logic [7:0] w_pending_next;
  logic [7:0] w_in_service_next;
  logic       w_gie_next;
  logic       w_int_req_next;
  logic [2:0] w_int_id_next;
  logic [7:0] w_int_vec_next;

  // Two synchronizer stages plus a history flop; the edge is taken between
  // the second stage and the history so it is already metastability-safe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= i_irq;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_edge = r_s2 & ~r_s3;

  // Mask is registered, so a write only influences selection next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask <= '0;
    end else if (i_mask_we) begin
      r_mask <= i_mask_d;
    end
  end

`ifdef NESTING_EN
  // A line may only interrupt if no in-service bit at its own index or
  // above (lower index) is set, i.e. it is strictly more urgent.
  always_comb begin : prio_nest
    logic w_seen;
    w_seen    = 1'b0;
    w_prio_ok = '0;
    for (int i = 0; i < 8; i++) begin
      w_seen       = w_seen | r_in_service[i];
      w_prio_ok[i] = ~w_seen;
    end
  end
`else
  // Without nesting, any active handler blocks all new requests.
  assign w_prio_ok = {8{~|r_in_service}};
`endif

  assign w_cand = r_pending & r_mask & {8{r_gie}} & w_prio_ok;

  // Lowest index wins: scan downward so the last hit is the lowest bit.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_id    = '0;
    for (int i = 7; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_win_valid = 1'b1;
        w_win_id    = 3'(i);
      end
    end
  end

  assign w_win_vec = VEC_BASE + (8'(w_win_id) << VEC_SHIFT);

  // The latched line stays offered only while it is still pending, unmasked
  // and gie is set; in-service changes cannot happen while in REQ without
  // an ack, so they are not rechecked here.
  assign w_latched_ok = r_pending[r_int_id] & r_mask[r_int_id] & r_gie;
  assign w_ack_taken  = (r_state == REQ) & bus.int_ack;
  assign w_reti_valid = bus.reti & (|r_in_service);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_int_req <= 1'b0;
      r_int_id  <= '0;
      r_int_vec <= '0;
    end else begin
      r_state   <= w_state_next;
      r_int_req <= w_int_req_next;
      r_int_id  <= w_int_id_next;
      r_int_vec <= w_int_vec_next;
    end
  end

  // Request FSM. id and vec are captured on the IDLE->REQ transition and
  // then frozen, so a more urgent late arrival waits for the next round.
  always_comb begin
    w_state_next   = r_state;
    w_int_req_next = r_int_req;
    w_int_id_next  = r_int_id;
    w_int_vec_next = r_int_vec;
    case (r_state)
      IDLE: begin
        w_int_req_next = 1'b0;
        if (w_win_valid) begin
          w_state_next   = REQ;
          w_int_req_next = 1'b1;
          w_int_id_next  = w_win_id;
          w_int_vec_next = w_win_vec;
        end
      end
      REQ: begin
        w_int_req_next = 1'b1;
        if (bus.int_ack || !w_latched_ok) begin
          w_state_next   = IDLE;
          w_int_req_next = 1'b0;
        end
      end
      default: begin
        w_state_next   = IDLE;
        w_int_req_next = 1'b0;
      end
    endcase
  end

  // A fresh edge is applied after the ack clear so the set wins.
  always_comb begin
    w_pending_next = r_pending;
    if (w_ack_taken) begin
      w_pending_next[r_int_id] = 1'b0;
    end
    w_pending_next = w_pending_next | w_edge;
  end

  // reti acts on the in-service value from before this cycle's ack; the
  // ack then adds its own bit on top.
  always_comb begin
    w_in_service_next = r_in_service;
    if (w_reti_valid) begin
`ifdef NESTING_EN
      w_in_service_next = r_in_service & (r_in_service - 8'd1);
`else
      w_in_service_next = '0;
`endif
    end
    if (w_ack_taken) begin
      w_in_service_next[r_int_id] = 1'b1;
    end
  end

  // gie precedence, lowest to highest: hold, ack clear, ei, reti, di.
  always_comb begin
    w_gie_next = r_gie;
    if (w_ack_taken) begin
      w_gie_next = 1'b0;
    end
    if (i_ien_set) begin
      w_gie_next = 1'b1;
    end
    if (w_reti_valid) begin
      w_gie_next = 1'b1;
    end
    if (i_ien_clr) begin
      w_gie_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending    <= '0;
      r_in_service <= '0;
      r_gie        <= 1'b0;
    end else begin
      r_pending    <= w_pending_next;
      r_in_service <= w_in_service_next;
      r_gie        <= w_gie_next;
    end
  end

  assign bus.int_req   = r_int_req;
  assign bus.int_id    = r_int_id;
  assign bus.int_vec   = r_int_vec;
  assign o_pending     = r_pending;
  assign o_in_service  = r_in_service;

endmodule

// File: tb/tb_controlador_int.sv
// ---------------------------------------------------------------------------
// tb_controlador_int
//   Directed testbench for controlador_int. Each scenario task drives its own
//   stimulus and compares outputs against hand-computed values. Inputs change
//   1 time unit after a rising edge; outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_controlador_int;

  logic       clk;
  logic       rst;
  logic [7:0] irq;
  logic       maskWe;
  logic [7:0] maskD;
  logic       ienSet;
  logic       ienClr;
  logic [7:0] pending;
  logic [7:0] inService;

  int checks;
  int errors;

  controlador_int_if bus ();

  controlador_int dut (
    .clk          (clk),
    .rst          (rst),
    .i_irq        (irq),
    .i_mask_we    (maskWe),
    .i_mask_d     (maskD),
    .i_ien_set    (ienSet),
    .i_ien_clr    (ienClr),
    .bus          (bus),
    .o_pending    (pending),
    .o_in_service (inService)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    irq         = '0;
    maskWe      = 1'b0;
    maskD       = '0;
    ienSet      = 1'b0;
    ienClr      = 1'b0;
    bus.int_ack = 1'b0;
    bus.reti    = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic enable_all();
    maskWe = 1'b1;
    maskD  = 8'hFF;
    ienSet = 1'b1;
    tick(1);
    maskWe = 1'b0;
    ienSet = 1'b0;
  endtask

  task automatic pulse_ack();
    bus.int_ack = 1'b1;
    tick(1);
    bus.int_ack = 1'b0;
  endtask

  task automatic pulse_reti();
    bus.reti = 1'b1;
    tick(1);
    bus.reti = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    enable_all();
    irq = 8'h40;
    tick(4);
    checks++;
    if (bus.int_req !== 1'b1 || bus.int_id !== 3'd6 || bus.int_vec !== 8'h08) begin
      errors++;
      $display("[TB] FAIL reset_prereq: req=%b id=%0d vec=%h, expected req=1 id=6 vec=08",
               bus.int_req, bus.int_id, bus.int_vec);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (bus.int_req !== 1'b0 || bus.int_id !== 3'd0 || bus.int_vec !== 8'h00 ||
        pending !== 8'h00 || inService !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_async: req=%b id=%0d vec=%h pend=%h isv=%h, expected all 0",
               bus.int_req, bus.int_id, bus.int_vec, pending, inService);
    end
    tick(1);
    rst = 1'b0;
    tick(5);
    checks++;
    if (pending !== 8'h40 || bus.int_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_masked: pend=%h req=%b, expected pend=40 req=0",
               pending, bus.int_req);
    end
  endtask

  task automatic test_single_line();
    do_reset();
    enable_all();
    irq = 8'h08;
    tick(3);
    checks++;
    if (pending !== 8'h08 || bus.int_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_pending: pend=%h req=%b, expected pend=08 req=0",
               pending, bus.int_req);
    end
    tick(1);
    checks++;
    if (bus.int_req !== 1'b1 || bus.int_id !== 3'd3 || bus.int_vec !== 8'hFC) begin
      errors++;
      $display("[TB] FAIL single_req: req=%b id=%0d vec=%h, expected req=1 id=3 vec=FC",
               bus.int_req, bus.int_id, bus.int_vec);
    end
    pulse_ack();
    checks++;
    if (bus.int_req !== 1'b0 || pending !== 8'h00 || inService !== 8'h08 ||
        dut.r_gie !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_ack: req=%b pend=%h isv=%h gie=%b, expected 0/00/08/0",
               bus.int_req, pending, inService, dut.r_gie);
    end
  endtask

  task automatic test_priority();
    do_reset();
    enable_all();
    irq = 8'h24;
    tick(4);
    checks++;
    if (bus.int_req !== 1'b1 || bus.int_id !== 3'd2 || bus.int_vec !== 8'hF8 ||
        pending !== 8'h24) begin
      errors++;
      $display("[TB] FAIL prio_pick: req=%b id=%0d vec=%h pend=%h, expected 1/2/F8/24",
               bus.int_req, bus.int_id, bus.int_vec, pending);
    end
    irq = 8'h25;
    tick(4);
    checks++;
    if (bus.int_req !== 1'b1 || bus.int_id !== 3'd2 || bus.int_vec !== 8'hF8 ||
        pending !== 8'h25) begin
      errors++;
      $display("[TB] FAIL prio_freeze: req=%b id=%0d vec=%h pend=%h, expected 1/2/F8/25",
               bus.int_req, bus.int_id, bus.int_vec, pending);
    end
    pulse_ack();
    checks++;
    if (bus.int_req !== 1'b0 || inService !== 8'h04 || pending !== 8'h21) begin
      errors++;
      $display("[TB] FAIL prio_ack: req=%b isv=%h pend=%h, expected 0/04/21",
               bus.int_req, inService, pending);
    end
    ienSet = 1'b1;
    tick(1);
    ienSet = 1'b0;
    tick(1);
`ifdef NESTING_EN
    checks++;
    if (bus.int_req !== 1'b1 || bus.int_id !== 3'd0 || bus.int_vec !== 8'hF0) begin
      errors++;
      $display("[TB] FAIL prio_nest: req=%b id=%0d vec=%h, expected 1/0/F0",
               bus.int_req, bus.int_id, bus.int_vec);
    end
`else
    checks++;
    if (bus.int_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL prio_nonest_block: req=%b, expected 0", bus.int_req);
    end
    pulse_reti();
    checks++;
    if (inService !== 8'h00 || bus.int_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL prio_reti: isv=%h req=%b, expected 00/0", inService, bus.int_req);
    end
    tick(1);
    checks++;
    if (bus.int_req !== 1'b1 || bus.int_id !== 3'd0 || bus.int_vec !== 8'hF0) begin
      errors++;
      $display("[TB] FAIL prio_after_reti: req=%b id=%0d vec=%h, expected 1/0/F0",
               bus.int_req, bus.int_id, bus.int_vec);
    end
`endif
  endtask

  task automatic test_withdraw();
    do_reset();
    enable_all();
    irq = 8'h10;
    tick(4);
    checks++;
    if (bus.int_req !== 1'b1 || bus.int_id !== 3'd4 || bus.int_vec !== 8'h00) begin
      errors++;
      $display("[TB] FAIL wd_req_wrap: req=%b id=%0d vec=%h, expected 1/4/00",
               bus.int_req, bus.int_id, bus.int_vec);
    end
    maskWe = 1'b1;
    maskD  = 8'hEF;
    tick(1);
    maskWe = 1'b0;
    checks++;
    if (bus.int_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wd_mask_delay: req=%b, expected 1", bus.int_req);
    end
    tick(1);
    checks++;
    if (bus.int_req !== 1'b0 || pending !== 8'h10) begin
      errors++;
      $display("[TB] FAIL wd_drop: req=%b pend=%h, expected 0/10", bus.int_req, pending);
    end
    pulse_ack();
    checks++;
    if (pending !== 8'h10 || inService !== 8'h00) begin
      errors++;
      $display("[TB] FAIL wd_idle_ack: pend=%h isv=%h, expected 10/00", pending, inService);
    end
    maskWe = 1'b1;
    maskD  = 8'hFF;
    tick(1);
    maskWe = 1'b0;
    checks++;
    if (bus.int_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wd_restore_early: req=%b, expected 0", bus.int_req);
    end
    tick(1);
    checks++;
    if (bus.int_req !== 1'b1 || bus.int_id !== 3'd4) begin
      errors++;
      $display("[TB] FAIL wd_restore: req=%b id=%0d, expected 1/4", bus.int_req, bus.int_id);
    end
  endtask

  task automatic test_reti();
    do_reset();
    enable_all();
`ifdef NESTING_EN
    irq = 8'h20;
    tick(4);
    pulse_ack();
    ienSet = 1'b1;
    tick(1);
    ienSet = 1'b0;
    irq = 8'h24;
    tick(4);
    checks++;
    if (bus.int_req !== 1'b1 || bus.int_id !== 3'd2) begin
      errors++;
      $display("[TB] FAIL reti_nest_req: req=%b id=%0d, expected 1/2", bus.int_req, bus.int_id);
    end
    pulse_ack();
    checks++;
    if (inService !== 8'h24 || dut.r_gie !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reti_setup: isv=%h gie=%b, expected 24/0", inService, dut.r_gie);
    end
    pulse_reti();
    checks++;
    if (inService !== 8'h20 || dut.r_gie !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reti_lowest: isv=%h gie=%b, expected 20/1", inService, dut.r_gie);
    end
    pulse_reti();
`else
    irq = 8'h02;
    tick(4);
    pulse_ack();
    checks++;
    if (inService !== 8'h02 || dut.r_gie !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reti_setup: isv=%h gie=%b, expected 02/0", inService, dut.r_gie);
    end
    pulse_reti();
`endif
    checks++;
    if (inService !== 8'h00 || dut.r_gie !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reti_clear: isv=%h gie=%b, expected 00/1", inService, dut.r_gie);
    end
    ienClr = 1'b1;
    tick(1);
    ienClr = 1'b0;
    pulse_reti();
    checks++;
    if (inService !== 8'h00 || dut.r_gie !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reti_empty: isv=%h gie=%b, expected 00/0", inService, dut.r_gie);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    enable_all();
    irq = 8'h02;
    tick(4);
    irq = 8'h00;
    tick(3);
    checks++;
    if (bus.int_req !== 1'b1 || bus.int_id !== 3'd1) begin
      errors++;
      $display("[TB] FAIL sim_req: req=%b id=%0d, expected 1/1", bus.int_req, bus.int_id);
    end
    irq = 8'h02;
    tick(2);
    pulse_ack();
    checks++;
    if (pending !== 8'h02 || inService !== 8'h02 || bus.int_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sim_set_wins: pend=%h isv=%h req=%b, expected 02/02/0",
               pending, inService, bus.int_req);
    end
    ienSet = 1'b1;
    tick(1);
    ienSet = 1'b0;
    checks++;
    if (dut.r_gie !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sim_ei: gie=%b, expected 1", dut.r_gie);
    end
    ienSet = 1'b1;
    ienClr = 1'b1;
    tick(1);
    ienSet = 1'b0;
    ienClr = 1'b0;
    checks++;
    if (dut.r_gie !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sim_ei_di: gie=%b, expected 0", dut.r_gie);
    end
    bus.reti = 1'b1;
    ienClr   = 1'b1;
    tick(1);
    bus.reti = 1'b0;
    ienClr   = 1'b0;
    checks++;
    if (inService !== 8'h00 || dut.r_gie !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sim_reti_di: isv=%h gie=%b, expected 00/0", inService, dut.r_gie);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_line();
    test_priority();
    test_withdraw();
    test_reti();
    test_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
